// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for the two-requester SRAM arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM.
interface sram_arbiter_if #(
  parameter int ADR = 8,
  parameter int DAT = 8
);
  logic           ReqA;
  logic           ReqB;
  logic           WrA;
  logic           WrB;
  logic [ADR-1:0] AddrA;
  logic [ADR-1:0] AddrB;
  logic [DAT-1:0] WDataA;
  logic [DAT-1:0] WDataB;
  logic           GntA;
  logic           GntB;
  logic           RdValidA;
  logic           RdValidB;
  logic [DAT-1:0] RdDataA;
  logic [DAT-1:0] RdDataB;
  logic           SramCS;
  logic           SramWE;
  logic           SramRE;
  logic [ADR-1:0] SramAddr;
  logic [DAT-1:0] SramDIn;
  logic [DAT-1:0] SramDOut;

  modport master (
    output ReqA, ReqB, WrA, WrB, AddrA, AddrB, WDataA, WDataB, SramDOut,
    input  GntA, GntB, RdValidA, RdValidB, RdDataA, RdDataB,
    input  SramCS, SramWE, SramRE, SramAddr, SramDIn
  );

  modport slave (
    input  ReqA, ReqB, WrA, WrB, AddrA, AddrB, WDataA, WDataB, SramDOut,
    output GntA, GntB, RdValidA, RdValidB, RdDataA, RdDataB,
    output SramCS, SramWE, SramRE, SramAddr, SramDIn
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter/sequencer giving two requesters access to one single-port
// synchronous SRAM, one operation in flight at a time; all outputs registered.
module sram_arbiter #(
  parameter int ADR = 8,
  parameter int DAT = 8
) (
  input logic           Clock,
  input logic           Reset,
  sram_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CMD    = 2'd1;
  localparam logic [1:0] RDWAIT = 2'd2;

  logic [1:0]     state_r;
  logic           last_gnt_r;  // 1 = B was granted last
  logic           cur_id_r;
  logic           cur_wr_r;
  logic           gnt_a_r;
  logic           gnt_b_r;
  logic           rdv_a_r;
  logic           rdv_b_r;
  logic           cs_r;
  logic           we_r;
  logic           re_r;
  logic [ADR-1:0] addr_r;
  logic [DAT-1:0] din_r;
  logic [DAT-1:0] rdata_a_r;
  logic [DAT-1:0] rdata_b_r;

  logic           any_req_s;
  logic           win_b_s;
  logic           win_wr_s;
  logic [ADR-1:0] win_addr_s;
  logic [DAT-1:0] win_data_s;

  // Winner selection: a tie goes to whichever requester was not granted last
  always_comb begin
    any_req_s = bus.ReqA | bus.ReqB;
    if (bus.ReqA && bus.ReqB) begin
      win_b_s = ~last_gnt_r;
    end else begin
      win_b_s = bus.ReqB;
    end
    if (win_b_s) begin
      win_wr_s   = bus.WrB;
      win_addr_s = bus.AddrB;
      win_data_s = bus.WDataB;
    end else begin
      win_wr_s   = bus.WrA;
      win_addr_s = bus.AddrA;
      win_data_s = bus.WDataA;
    end
  end

  // Sequencer: IDLE issues a command, CMD retires it, RDWAIT returns read data
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b1;
      cur_id_r   <= 1'b0;
      cur_wr_r   <= 1'b0;
      gnt_a_r    <= 1'b0;
      gnt_b_r    <= 1'b0;
      rdv_a_r    <= 1'b0;
      rdv_b_r    <= 1'b0;
      cs_r       <= 1'b0;
      we_r       <= 1'b0;
      re_r       <= 1'b0;
      addr_r     <= {ADR{1'b0}};
      din_r      <= {DAT{1'b0}};
      rdata_a_r  <= {DAT{1'b0}};
      rdata_b_r  <= {DAT{1'b0}};
    end else begin
      gnt_a_r <= 1'b0;
      gnt_b_r <= 1'b0;
      rdv_a_r <= 1'b0;
      rdv_b_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            addr_r     <= win_addr_s;
            din_r      <= win_data_s;
            cs_r       <= 1'b1;
            we_r       <= win_wr_s;
            re_r       <= ~win_wr_s;
            gnt_a_r    <= ~win_b_s;
            gnt_b_r    <= win_b_s;
            last_gnt_r <= win_b_s;
            cur_id_r   <= win_b_s;
            cur_wr_r   <= win_wr_s;
            state_r    <= CMD;
          end
        end
        CMD: begin
          // SRAM samples the command on this edge; address/data stay put
          cs_r    <= 1'b0;
          we_r    <= 1'b0;
          re_r    <= 1'b0;
          state_r <= cur_wr_r ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (cur_id_r) begin
            rdata_b_r <= bus.SramDOut;
            rdv_b_r   <= 1'b1;
          end else begin
            rdata_a_r <= bus.SramDOut;
            rdv_a_r   <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: begin
          cs_r    <= 1'b0;
          we_r    <= 1'b0;
          re_r    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.GntA     = gnt_a_r;
  assign bus.GntB     = gnt_b_r;
  assign bus.RdValidA = rdv_a_r;
  assign bus.RdValidB = rdv_b_r;
  assign bus.RdDataA  = rdata_a_r;
  assign bus.RdDataB  = rdata_b_r;
  assign bus.SramCS   = cs_r;
  assign bus.SramWE   = we_r;
  assign bus.SramRE   = re_r;
  assign bus.SramAddr = addr_r;
  assign bus.SramDIn  = din_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a behavioural SRAM plus reference memory;
// expected commands and read data are queued at stimulus time and checked on output.
module tb_sram_arbiter;

  logic Clock = 1'b0;
  logic Reset;

  sram_arbiter_if #(.ADR(8), .DAT(8)) bus();

  sram_arbiter #(.ADR(8), .DAT(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       id;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] rd_a_q[$];
  logic [7:0] rd_b_q[$];
  logic [7:0] ref_mem  [256];
  logic [7:0] sram_mem [256];
  logic       last_m;
  cmd_t       mon_c;
  logic [7:0] mon_d;
  int total = 0, bad = 0, cyc = 0;
  int gnt_a_cyc = 0, gnt_b_cyc = 0, rdv_a_cyc = 0, rdv_b_cyc = 0;

  // behavioural SRAM: write on CS&WE, registered read data on CS&RE
  always @(posedge Clock) begin
    if (bus.SramCS) begin
      if (bus.SramWE) sram_mem[bus.SramAddr] <= bus.SramDIn;
      if (bus.SramRE) bus.SramDOut <= sram_mem[bus.SramAddr];
    end
  end

  // output monitor: pops the scoreboard on every grant and read return
  always @(negedge Clock) begin
    cyc++;
    if (!Reset) begin
      total++;
      if ((bus.SramWE && bus.SramRE) || (bus.GntA && bus.GntB) ||
          ((bus.GntA || bus.GntB) && (bus.RdValidA || bus.RdValidB))) begin
        bad++;
        $display("FAIL invariant: we=%b re=%b gntA=%b gntB=%b rdvA=%b rdvB=%b, required no overlap",
                 bus.SramWE, bus.SramRE, bus.GntA, bus.GntB, bus.RdValidA, bus.RdValidB);
      end
      if (bus.GntA || bus.GntB) begin
        if (bus.GntA) gnt_a_cyc = cyc;
        if (bus.GntB) gnt_b_cyc = cyc;
        total++;
        if (cmd_q.size() == 0) begin
          bad++;
          $display("FAIL grant: unexpected grant A=%b B=%b at cycle %0d", bus.GntA, bus.GntB, cyc);
        end else begin
          mon_c = cmd_q.pop_front();
          if ({bus.GntB, bus.SramCS, bus.SramWE, bus.SramRE, bus.SramAddr} !==
              {mon_c.id, 1'b1, mon_c.wr, ~mon_c.wr, mon_c.addr} ||
              (mon_c.wr && bus.SramDIn !== mon_c.data)) begin
            bad++;
            $display("FAIL grant: got id=%b cs=%b we=%b re=%b addr=%h din=%h, required id=%b wr=%b addr=%h din=%h",
                     bus.GntB, bus.SramCS, bus.SramWE, bus.SramRE, bus.SramAddr, bus.SramDIn,
                     mon_c.id, mon_c.wr, mon_c.addr, mon_c.data);
          end
        end
      end
      if (bus.RdValidA) begin
        rdv_a_cyc = cyc;
        total++;
        if (rd_a_q.size() == 0) begin
          bad++;
          $display("FAIL rdvalid_a: unexpected pulse, data=%h", bus.RdDataA);
        end else begin
          mon_d = rd_a_q.pop_front();
          if (bus.RdDataA !== mon_d) begin
            bad++;
            $display("FAIL rddata_a: got %h required %h", bus.RdDataA, mon_d);
          end
        end
      end
      if (bus.RdValidB) begin
        rdv_b_cyc = cyc;
        total++;
        if (rd_b_q.size() == 0) begin
          bad++;
          $display("FAIL rdvalid_b: unexpected pulse, data=%h", bus.RdDataB);
        end else begin
          mon_d = rd_b_q.pop_front();
          if (bus.RdDataB !== mon_d) begin
            bad++;
            $display("FAIL rddata_b: got %h required %h", bus.RdDataB, mon_d);
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic id, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    cmd_q.push_back('{id: id, wr: wr, addr: addr, data: data});
    if (wr) ref_mem[addr] = data;
    else if (id) rd_b_q.push_back(ref_mem[addr]);
    else rd_a_q.push_back(ref_mem[addr]);
    last_m = id;
  endtask

  task automatic set_req(input logic id, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    if (id) begin
      bus.WrB = wr; bus.AddrB = addr; bus.WDataB = data; bus.ReqB = 1'b1;
    end else begin
      bus.WrA = wr; bus.AddrA = addr; bus.WDataA = data; bus.ReqA = 1'b1;
    end
  endtask

  // tie between A and B: expected order comes from the bench's own last-grant model
  task automatic tie(input logic wa, input logic [7:0] aa, input logic [7:0] da,
                     input logic wb, input logic [7:0] ab, input logic [7:0] db);
    if (last_m) begin
      push_cmd(1'b0, wa, aa, da); push_cmd(1'b1, wb, ab, db);
    end else begin
      push_cmd(1'b1, wb, ab, db); push_cmd(1'b0, wa, aa, da);
    end
    set_req(1'b0, wa, aa, da);
    set_req(1'b1, wb, ab, db);
  endtask

  // drop each Req right after its Gnt is seen; returns in the cycle after the last grant
  task automatic run_until_granted();
    int n = 0;
    while ((bus.ReqA || bus.ReqB) && n < 60) begin
      @(posedge Clock); #1;
      if (bus.GntA) bus.ReqA = 1'b0;
      if (bus.GntB) bus.ReqB = 1'b0;
      n++;
    end
    total++;
    if (bus.ReqA || bus.ReqB) begin
      bad++;
      $display("FAIL grant_timeout: reqA=%b reqB=%b still pending, required granted", bus.ReqA, bus.ReqB);
      bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cmd_q.size() + rd_a_q.size() + rd_b_q.size()) != 0 && n < 40) begin
      @(posedge Clock); #1;
      n++;
    end
    total++;
    if ((cmd_q.size() + rd_a_q.size() + rd_b_q.size()) != 0) begin
      bad++;
      $display("FAIL drain_timeout: cmd=%0d rdA=%0d rdB=%0d outstanding, required 0",
               cmd_q.size(), rd_a_q.size(), rd_b_q.size());
      cmd_q.delete(); rd_a_q.delete(); rd_b_q.delete();
    end
    @(posedge Clock); #1;
  endtask

  task automatic check_outputs_zero(input string name);
    logic [38:0] v;
    v = {bus.GntA, bus.GntB, bus.RdValidA, bus.RdValidB, bus.SramCS, bus.SramWE, bus.SramRE,
         bus.SramAddr, bus.SramDIn, bus.RdDataA, bus.RdDataB};
    total++;
    if (v !== 39'd0) begin
      bad++;
      $display("FAIL %s: outputs=%h required 0", name, v);
    end
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset = 1'b1;
    cmd_q.delete(); rd_a_q.delete(); rd_b_q.delete();
    last_m = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.ReqA = 1'b0; bus.ReqB = 1'b0; bus.WrA = 1'b0; bus.WrB = 1'b0;
    bus.AddrA = 8'h00; bus.AddrB = 8'h00; bus.WDataA = 8'h00; bus.WDataB = 8'h00;
    last_m = 1'b1;
    repeat (2) @(negedge Clock);
    check_outputs_zero("reset_state");
    Reset = 1'b0;
  endtask

  task automatic test_write_read_a();
    push_cmd(1'b0, 1'b1, 8'd3, 8'h5A);
    set_req(1'b0, 1'b1, 8'd3, 8'h5A);
    run_until_granted();
    wait_idle();
    total++;
    if ({bus.SramCS, bus.SramAddr, bus.SramDIn} !== {1'b0, 8'd3, 8'h5A}) begin
      bad++;
      $display("FAIL hold_after_write: cs=%b addr=%h din=%h required 0/03/5a", bus.SramCS, bus.SramAddr, bus.SramDIn);
    end
    push_cmd(1'b0, 1'b0, 8'd3, 8'h00);
    set_req(1'b0, 1'b0, 8'd3, 8'h00);
    run_until_granted();
    wait_idle();
    total++;
    if (rdv_a_cyc - gnt_a_cyc != 2) begin
      bad++;
      $display("FAIL read_latency: got %0d cycles required 2", rdv_a_cyc - gnt_a_cyc);
    end
    total++;
    if (bus.RdDataA !== 8'h5A) begin
      bad++;
      $display("FAIL rddata_hold: got %h required 5a", bus.RdDataA);
    end
  endtask

  task automatic test_first_tie();
    pulse_reset();
    tie(1'b1, 8'd1, 8'h11, 1'b1, 8'd2, 8'h22);
    run_until_granted();
    wait_idle();
    total++;
    if (gnt_b_cyc - gnt_a_cyc != 2) begin
      bad++;
      $display("FAIL tie_spacing: gntB-gntA=%0d required 2", gnt_b_cyc - gnt_a_cyc);
    end
    tie(1'b0, 8'd1, 8'h00, 1'b0, 8'd2, 8'h00);
    run_until_granted();
    wait_idle();
  endtask

  task automatic test_fairness();
    int n = 0, prev = 0, i = 0;
    logic [7:0] ka = 8'h00, kb = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (last_m) begin push_cmd(1'b0, 1'b1, 8'h20, 8'hA0 + ka); ka++; end
      else begin push_cmd(1'b1, 1'b1, 8'h21, 8'hB0 + kb); kb++; end
    end
    set_req(1'b0, 1'b1, 8'h20, 8'hA0);
    set_req(1'b1, 1'b1, 8'h21, 8'hB0);
    while (n < 8 && i < 60) begin
      @(posedge Clock); #1;
      i++;
      if (bus.GntA || bus.GntB) begin
        n++;
        if (bus.GntA) bus.WDataA = bus.WDataA + 8'h01;
        if (bus.GntB) bus.WDataB = bus.WDataB + 8'h01;
        if (n > 1) begin
          total++;
          if (i - prev != 2) begin
            bad++;
            $display("FAIL fair_spacing: grant %0d came %0d cycles after previous, required 2", n, i - prev);
          end
        end
        prev = i;
      end
    end
    bus.ReqA = 1'b0; bus.ReqB = 1'b0;
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL fair_count: got %0d grants required 8", n);
    end
    wait_idle();
  endtask

  task automatic test_interleaved();
    push_cmd(1'b1, 1'b1, 8'd5, 8'h77);
    set_req(1'b1, 1'b1, 8'd5, 8'h77);
    run_until_granted();
    wait_idle();
    tie(1'b0, 8'd5, 8'h00, 1'b1, 8'd5, 8'h99);
    run_until_granted();
    wait_idle();
    total++;
    if (bus.RdDataA !== 8'h77 || gnt_b_cyc <= rdv_a_cyc) begin
      bad++;
      $display("FAIL interleave: rdDataA=%h gntB_cyc=%0d rdvA_cyc=%0d, required 77 and gntB after rdvA",
               bus.RdDataA, gnt_b_cyc, rdv_a_cyc);
    end
    push_cmd(1'b0, 1'b0, 8'd5, 8'h00);
    set_req(1'b0, 1'b0, 8'd5, 8'h00);
    run_until_granted();
    wait_idle();
  endtask

  task automatic test_reset_mid_read();
    cmd_q.push_back('{id: 1'b0, wr: 1'b0, addr: 8'd3, data: 8'h00});
    last_m = 1'b0;
    set_req(1'b0, 1'b0, 8'd3, 8'h00);
    run_until_granted();
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid_read");
    cmd_q.delete(); rd_a_q.delete(); rd_b_q.delete();
    last_m = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    tie(1'b1, 8'd9, 8'h01, 1'b1, 8'd10, 8'h02);
    run_until_granted();
    wait_idle();
    total++;
    if (gnt_a_cyc >= gnt_b_cyc) begin
      bad++;
      $display("FAIL tie_after_reset: gntA_cyc=%0d gntB_cyc=%0d, required A first", gnt_a_cyc, gnt_b_cyc);
    end
  endtask

  task automatic test_late_change();
    push_cmd(1'b0, 1'b1, 8'd7, 8'h3C);
    set_req(1'b0, 1'b1, 8'd7, 8'h3C);
    run_until_granted();
    bus.AddrA = 8'hE7;
    bus.WDataA = 8'hFF;
    @(posedge Clock); #1;
    total++;
    if ({bus.SramAddr, bus.SramDIn} !== {8'd7, 8'h3C}) begin
      bad++;
      $display("FAIL late_change: addr=%h din=%h required 07/3c", bus.SramAddr, bus.SramDIn);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_write_read_a();
    test_first_tie();
    test_fairness();
    test_interleaved();
    test_reset_mid_read();
    test_late_change();
    repeat (3) @(posedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
